// File: rtl/apb4_cpuif_pkg.sv
// rtl/apb4_cpuif_pkg.sv - shared types and helpers for the APB4 CPU-interface responder
//
// Contents:
//   state_t        - transfer state (IDLE, REQ, WAIT, DONE)
//   BYTE_BITS      - bits covered by one byte strobe
//   MAX_STRB       - widest strobe vector supported (64-bit bus)
//   strb_to_biten  - expands byte strobes into per-bit enables
package apb4_cpuif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BYTE_BITS = 8;
    localparam int MAX_STRB  = 8;

    // Always produces the 64-bit expansion; callers keep the low DATA_WIDTH bits.
    function automatic logic [MAX_STRB*BYTE_BITS-1:0] strb_to_biten(
        input logic [MAX_STRB-1:0] strb
    );
        logic [MAX_STRB*BYTE_BITS-1:0] biten;
        biten = '0;
        for (int i = 0; i < MAX_STRB; i++) begin
            biten[i*BYTE_BITS +: BYTE_BITS] = {BYTE_BITS{strb[i]}};
        end
        return biten;
    endfunction

endpackage

// File: rtl/cpuif_ack_watchdog.sv
// rtl/cpuif_ack_watchdog.sv - acknowledge watchdog counter with expiry flag
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - request issued this cycle; restarts the count at 1 for the next cycle
//   run       - responder is waiting for an acknowledge
//   expired   - TIMEOUT_CYCLES cycles have elapsed since the request without an ack
module cpuif_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // count equals the number of cycles elapsed since the request cycle,
    // saturating at the limit so it cannot wrap while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(1);
        end else if (run && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == CNT_MAX);

endmodule

// File: rtl/apb4_cpuif_responder.sv
// rtl/apb4_cpuif_responder.sv - APB4 completer that bridges to a regblock CPU-interface strobe bus
//
// Each APB4 transfer becomes one single-cycle cpuif request; the matching
// acknowledge completes the APB transfer with registered data and error.
// Optional feature: define APB4_RESP_TIMEOUT_EN to add an acknowledge
// watchdog that completes the transfer with an error after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   s_apb_*                   - APB4 completer port (pprot ignored)
//   cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten
//                             - request strobe bus to the register core
//   cpuif_req_stall_wr/rd     - core back-pressure per direction
//   cpuif_rd_ack/err/data     - read completion
//   cpuif_wr_ack/err          - write completion
module apb4_cpuif_responder
    import apb4_cpuif_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_apb_psel,
    input  logic                    s_apb_penable,
    input  logic                    s_apb_pwrite,
    input  logic [2:0]              s_apb_pprot,
    input  logic [ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [DATA_WIDTH-1:0]   s_apb_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
    output logic                    s_apb_pready,
    output logic [DATA_WIDTH-1:0]   s_apb_prdata,
    output logic                    s_apb_pslverr,
    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
    input  logic                    cpuif_req_stall_wr,
    input  logic                    cpuif_req_stall_rd,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

    state_t state, state_nxt;
    logic   aborted, aborted_nxt;
    logic   req_stall, ack_hit, ack_err, tmo_expired;
    logic   rsp_load, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;
    logic [MAX_STRB-1:0]   strb_pad;
    logic [MAX_STRB*BYTE_BITS-1:0] biten_wide;
    logic unused_inputs;

    // Direction-qualified views of the core handshake; the other direction is ignored.
    assign req_stall = cpuif_req_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    assign ack_hit   = cpuif_req_is_wr ? cpuif_wr_ack : cpuif_rd_ack;
    assign ack_err   = cpuif_req_is_wr ? cpuif_wr_err : cpuif_rd_err;
    assign cpuif_req = (state == REQ) && !req_stall;

    always_comb begin
        strb_pad = '0;
        strb_pad[STRB_W-1:0] = s_apb_pstrb;
        biten_wide = strb_to_biten(strb_pad);
    end

    assign unused_inputs = ^{s_apb_pprot, biten_wide};

`ifdef APB4_RESP_TIMEOUT_EN
    cpuif_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (cpuif_req),
        .run     (state == WAIT),
        .expired (tmo_expired)
    );
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        aborted_nxt  = aborted;
        rsp_load     = 1'b0;
        rsp_err_nxt  = 1'b0;
        rsp_data_nxt = '0;
        case (state)
            IDLE: begin
                if (s_apb_psel && !s_apb_penable) begin
                    state_nxt   = REQ;
                    aborted_nxt = 1'b0;
                end
            end
            REQ, WAIT: begin
                // A dropped psel is remembered so the eventual completion skips DONE.
                if (!s_apb_psel) begin
                    aborted_nxt = 1'b1;
                end
                if ((state == REQ) && req_stall) begin
                    state_nxt = REQ;
                end else if (ack_hit) begin
                    state_nxt    = aborted_nxt ? IDLE : DONE;
                    rsp_load     = !aborted_nxt;
                    rsp_err_nxt  = ack_err;
                    rsp_data_nxt = cpuif_req_is_wr ? '0 : cpuif_rd_data;
                end else if (tmo_expired) begin
                    state_nxt   = aborted_nxt ? IDLE : DONE;
                    rsp_load    = !aborted_nxt;
                    rsp_err_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            aborted         <= 1'b0;
            s_apb_pready    <= 1'b0;
            s_apb_prdata    <= '0;
            s_apb_pslverr   <= 1'b0;
            cpuif_req_is_wr <= 1'b0;
            cpuif_addr      <= '0;
            cpuif_wr_data   <= '0;
            cpuif_wr_biten  <= '0;
        end else begin
            state        <= state_nxt;
            aborted      <= aborted_nxt;
            s_apb_pready <= (state_nxt == DONE);
            if (rsp_load) begin
                s_apb_prdata  <= rsp_data_nxt;
                s_apb_pslverr <= rsp_err_nxt;
            end
            if ((state == IDLE) && s_apb_psel && !s_apb_penable) begin
                cpuif_req_is_wr <= s_apb_pwrite;
                cpuif_addr      <= s_apb_paddr & ~ADDR_MASK;
                cpuif_wr_data   <= s_apb_pwdata;
                cpuif_wr_biten  <= s_apb_pwrite ? biten_wide[DATA_WIDTH-1:0] : '0;
            end
        end
    end

endmodule

// File: doc/apb4_cpuif_responder.md
# apb4_cpuif_responder

APB4 completer front-end for a generated register block. It accepts APB4 transfers from a system bus and converts each one into a single-cycle request on the register block's internal CPU-interface strobe bus. It waits for the matching read or write acknowledge, then completes the APB transfer with data and error status. It sits between the SoC interconnect and the `regblock` core, which the bus-initiator agent in the test environment drives from the opposite side.

## Interface
Parameters:
- ADDR_WIDTH, 12, APB byte-address width
- DATA_WIDTH, 32, bus data width; must be 8, 16, 32 or 64
- TIMEOUT_CYCLES, 64, acknowledge watchdog limit (used only with the timeout feature)

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  **asynchronous, active-high reset**
- s_apb_psel  in  1  APB select
- s_apb_penable  in  1  APB access phase
- s_apb_pwrite  in  1  1 = write
- s_apb_pprot  in  3  ignored
- s_apb_paddr  in  ADDR_WIDTH  byte address
- s_apb_pwdata  in  DATA_WIDTH  write data
- s_apb_pstrb  in  DATA_WIDTH/8  byte strobes
- s_apb_pready  out  1  transfer complete
- s_apb_prdata  out  DATA_WIDTH  read data
- s_apb_pslverr  out  1  transfer error
- cpuif_req  out  1  single-cycle request strobe
- cpuif_req_is_wr  out  1  request is a write
- cpuif_addr  out  ADDR_WIDTH  word-aligned address; low log2(DATA_WIDTH/8) bits are 0
- cpuif_wr_data  out  DATA_WIDTH  write data
- cpuif_wr_biten  out  DATA_WIDTH  bit enables (pstrb expanded ×8); 0 on reads
- cpuif_req_stall_wr  in  1  core cannot accept a write this cycle
- cpuif_req_stall_rd  in  1  core cannot accept a read this cycle
- cpuif_rd_ack  in  1  read complete
- cpuif_rd_err  in  1  read error (valid with rd_ack)
- cpuif_rd_data  in  DATA_WIDTH  read data (valid with rd_ack)
- cpuif_wr_ack  in  1  write complete
- cpuif_wr_err  in  1  write error (valid with wr_ack)

## Operation
- States: IDLE, REQ, WAIT, DONE. Only one transaction is ever outstanding.
- IDLE:
  - On `psel && !penable` (setup phase), register pwrite, the aligned address, pwdata and the expanded strobes.
  - Go to REQ.
- REQ:
  - Assert `cpuif_req` combinationally when the relevant stall input (wr or rd, per the latched direction) is 0.
  - While stalled, hold `req` low and stay in REQ.
  - On the unstalled cycle, go to WAIT, or directly to DONE if the matching ack is present in that same cycle.
- WAIT:
  - Accept only the ack matching the direction: `rd_ack` for reads, `wr_ack` for writes.
  - On ack, register prdata (reads only; 0 for writes) and pslverr (the matching err input), then go to DONE.
- DONE:
  - `pready` = 1 for exactly one cycle, then go to IDLE.
  - `pready` is 0 in every other state.
- Ignored inputs:
  - Acks arriving in IDLE, REQ-while-stalled or DONE are ignored.
  - A mismatched-direction ack is ignored in every state.
- psel deasserted mid-transfer (protocol violation):
  - An already-issued request still waits for its ack.
  - DONE is then skipped (pready stays 0) and the block returns to IDLE.
- Asynchronous reset mid-operation: immediate return to IDLE; any in-flight ack is discarded.

## Timing
- Reset values: pready, pslverr, cpuif_req, cpuif_req_is_wr = 0; prdata, cpuif_addr, cpuif_wr_data, cpuif_wr_biten = 0; state = IDLE.
- Minimum transfer, with no stall and ack in the request cycle:
  - Setup at edge 0.
  - `cpuif_req` during cycle 1.
  - `pready` during cycle 2.
  - Result: one APB wait state.
- Each stall cycle adds one cycle of latency.
- Each cycle between req and ack adds one cycle of latency.
- The pready/prdata/pslverr outputs are registered. `cpuif_req` is combinational from the state and the stall inputs.

## Configuration
- `APB4_RESP_TIMEOUT_EN` defined:
  - A counter starts when `cpuif_req` is issued.
  - If no matching ack arrives within TIMEOUT_CYCLES cycles, the block enters DONE with pslverr = 1 and prdata = 0.
  - A later ack is ignored.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - No counter is instantiated.
  - WAIT persists until an ack arrives.

## Structure
- Package `apb4_cpuif_pkg`:
  - state enum (`IDLE`, `REQ`, `WAIT`, `DONE`)
  - localparam for the strobe-to-biten expansion helper function
- Sub-module `cpuif_ack_watchdog`:
  - counter plus expiry flag
  - instantiated only under `APB4_RESP_TIMEOUT_EN`

## Test plan
- Write: addr 0x014, data 0xDEADBEEF, pstrb 0xF, wr_ack in the req cycle:
  - cpuif_addr = 0x014, biten = 0xFFFFFFFF
  - pready 2 cycles after setup, pslverr = 0
- Read: addr 0x008, rd_ack 3 cycles after req with data 0x12345678 → prdata = 0x12345678 in the pready cycle, pslverr = 0.
- Partial write: pstrb 0x5 → biten = 0x00FF00FF. Write with wr_err = 1 → pslverr = 1.
- `stall_rd` held 4 cycles on a read → cpuif_req asserts exactly once, on the first unstalled cycle. A simultaneous `stall_wr` has no effect.
- Reset asserted during WAIT:
  - All outputs 0 asynchronously.
  - A following ack produces no pready.
  - The next transfer completes normally.
- With `APB4_RESP_TIMEOUT_EN`, TIMEOUT_CYCLES = 8, no ack:
  - pready with pslverr = 1 and prdata = 0, 9 cycles after req.
  - A late ack is ignored.
